// File: rtl/mem_sram_access_pkg.sv
// ============================================================================
//  Module  : mem_sram_access_pkg
//  Purpose : Shared definitions for the MEM-stage data-memory access engine.
//            Memory-op codes, read-select (dre) codes, the default device
//            region tag, access-size and FSM state encodings, and a lane-mask
//            helper used by the lane generator.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_sram_access_pkg;

    // Memory-op codes carried on mem_op_i (store word arrives on mem_sw_i)
    localparam logic [2:0] OP_NONE = 3'd0;
    localparam logic [2:0] OP_LB   = 3'd1;
    localparam logic [2:0] OP_LBU  = 3'd2;
    localparam logic [2:0] OP_LH   = 3'd3;
    localparam logic [2:0] OP_LHU  = 3'd4;
    localparam logic [2:0] OP_LW   = 3'd5;
    localparam logic [2:0] OP_SB   = 3'd6;
    localparam logic [2:0] OP_SH   = 3'd7;

    // Read-select code: {unsigned, lane[3:0]}, lane bit 3 = byte offset 0
    localparam logic [4:0] DRE_NONE = 5'b00000;

    // addr[31:16] value of the device (MMIO) region
    localparam logic [15:0] DEV_TAG_DEFAULT = 16'hbfaf;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } size_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Byte lanes touched by an access of the given size at the given offset.
    // Offset 0 maps to lane bit 3 (data bits [31:24]).
    function automatic logic [3:0] lane_mask(input logic [1:0] offset, input size_t size);
        logic [3:0] m;
        m = 4'b0000;
        case (size)
            SZ_BYTE: m = 4'b1000 >> offset;
            SZ_HALF: m = offset[1] ? 4'b0011 : 4'b1100;
            SZ_WORD: m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_sram_access_if.sv
// ============================================================================
//  Module  : mem_sram_access_if
//  Purpose : SRAM-like data bus between the MEM-stage access engine (master)
//            and the data memory / bridge (slave).
//  Signals : data_req, data_wr, data_wstrb, data_addr, data_wdata  (master->slave)
//            data_addr_ok, data_data_ok, data_rdata                  (slave->master)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_sram_access_if #(
    parameter int ADDR_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_wstrb,
        output data_addr,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_wstrb,
        input  data_addr,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );
endinterface

`default_nettype wire

// File: rtl/mem_sram_access_lane_gen.sv
// ============================================================================
//  Module  : mem_sram_access_lane_gen
//  Purpose : Combinational decode of a memory op into bus lane controls.
//  Ports   : op, sw, addr_lo, device, wdata_in  -> decoded access
//            is_load, is_store                  -> access class
//            dre                                -> write-back read-select code
//            wstrb, wdata                       -> store lanes and placed data
//            adel, ades                         -> misaligned load / store
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_access_lane_gen
    import mem_sram_access_pkg::*;
(
    input  wire logic [2:0]  op,
    input  wire logic        sw,
    input  wire logic [1:0]  addr_lo,
    input  wire logic        device,
    input  wire logic [31:0] wdata_in,
    output logic             is_load,
    output logic             is_store,
    output logic [4:0]       dre,
    output logic [3:0]       wstrb,
    output logic [31:0]      wdata,
    output logic             adel,
    output logic             ades
);

    size_t       w_size;
    logic        w_unsigned;
    logic [3:0]  w_mask;
    logic        w_misalign;
    logic [31:0] w_swapped;
    logic [31:0] w_byte_hi;
    logic [31:0] w_placed;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        w_unsigned = 1'b0;
        w_size     = SZ_NONE;
        if (sw) begin
            is_store = 1'b1;
            w_size   = SZ_WORD;
        end else begin
            case (op)
                OP_LB:   begin is_load  = 1'b1; w_size = SZ_BYTE; end
                OP_LBU:  begin is_load  = 1'b1; w_size = SZ_BYTE; w_unsigned = 1'b1; end
                OP_LH:   begin is_load  = 1'b1; w_size = SZ_HALF; end
                OP_LHU:  begin is_load  = 1'b1; w_size = SZ_HALF; w_unsigned = 1'b1; end
                OP_LW:   begin is_load  = 1'b1; w_size = SZ_WORD; end
                OP_SB:   begin is_store = 1'b1; w_size = SZ_BYTE; end
                OP_SH:   begin is_store = 1'b1; w_size = SZ_HALF; end
                default: begin is_load  = 1'b0; end
            endcase
        end
    end

    assign w_mask     = lane_mask(addr_lo, w_size);
    assign w_misalign = ((w_size == SZ_HALF) && addr_lo[0]) ||
                        ((w_size == SZ_WORD) && (addr_lo != 2'b00));

    assign dre   = is_load  ? {w_unsigned, w_mask} : DRE_NONE;
    assign wstrb = is_store ? w_mask : 4'b0000;
    assign adel  = is_load  & w_misalign;
    assign ades  = is_store & w_misalign;

    // RAM region is byte-swapped: the CPU's lowest-address byte (rt[7:0])
    // travels in the lane of its offset, offset 0 being bits [31:24].
    assign w_swapped = {wdata_in[7:0], wdata_in[15:8], wdata_in[23:16], wdata_in[31:24]};
    assign w_byte_hi = {wdata_in[7:0], 24'h000000};

    always_comb begin
        w_placed = 32'h0000_0000;
        case (w_size)
            SZ_BYTE: w_placed = w_byte_hi >> {addr_lo, 3'b000};
            SZ_HALF: w_placed = addr_lo[1] ? {16'h0000, wdata_in[7:0], wdata_in[15:8]}
                                           : {wdata_in[7:0], wdata_in[15:8], 16'h0000};
            SZ_WORD: w_placed = w_swapped;
            default: w_placed = 32'h0000_0000;
        endcase
    end

    // Device registers see the store operand untouched; the strobe picks lanes.
    assign wdata = !is_store ? 32'h0000_0000 : (device ? wdata_in : w_placed);

endmodule

`default_nettype wire

// File: rtl/mem_sram_access.sv
// ============================================================================
//  Module  : mem_sram_access
//  Purpose : MEM-stage data-memory access engine. Issues one load/store per
//            pipeline slot over the req/addr_ok/data_ok bus, stalls the
//            pipeline while busy and hands write-back the raw load word.
//  Ports   : cpu_clk_50M, cpu_rst (async, active high)
//            mem_op_i, mem_sw_i, mem_addr_i, mem_wdata_i, flush_i  (from EX/MEM)
//            bus (master modport of mem_sram_access_if)
//            stall_req_o, dm_o, dre_o, device_o, adel_o, ades_o    (to pipeline)
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_sram_access
    import mem_sram_access_pkg::*;
#(
    parameter logic [15:0] DEV_TAG = DEV_TAG_DEFAULT,
    parameter int          ADDR_W  = 32
) (
    input  wire logic              cpu_clk_50M,
    input  wire logic              cpu_rst,
    input  wire logic [2:0]        mem_op_i,
    input  wire logic              mem_sw_i,
    input  wire logic [ADDR_W-1:0] mem_addr_i,
    input  wire logic [31:0]       mem_wdata_i,
    input  wire logic              flush_i,
    mem_sram_access_if.master      bus,
    output logic                   stall_req_o,
    output logic [31:0]            dm_o,
    output logic [4:0]             dre_o,
    output logic                   device_o,
    output logic                   adel_o,
    output logic                   ades_o
);

    state_t      r_state;
    state_t      w_next;
    logic        r_is_load;

    logic        w_is_load;
    logic        w_is_store;
    logic [4:0]  w_dre;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic        w_adel;
    logic        w_ades;
    logic        w_device;
    logic        w_launch;
    logic        w_accept;
    logic        w_resp;
    logic        w_kill;

    assign w_device = (mem_addr_i[ADDR_W-1 -: 16] == DEV_TAG);

    mem_sram_access_lane_gen u_lane_gen (
        .op       (mem_op_i),
        .sw       (mem_sw_i),
        .addr_lo  (mem_addr_i[1:0]),
        .device   (w_device),
        .wdata_in (mem_wdata_i),
        .is_load  (w_is_load),
        .is_store (w_is_store),
        .dre      (w_dre),
        .wstrb    (w_wstrb),
        .wdata    (w_wdata),
        .adel     (w_adel),
        .ades     (w_ades)
    );

    // The op stays parked in MEM while stall_req_o is high, so only the IDLE
    // state looks at it; REQ/WAIT/DONE ignore the held copy.
    assign w_launch = (r_state == ST_IDLE) && (w_is_load || w_is_store) &&
                      !w_adel && !w_ades && !flush_i && !cpu_rst;

    assign w_accept = (r_state == ST_REQ) && bus.data_addr_ok;

    // data_ok only counts once the address phase has been accepted.
    assign w_resp = (w_accept && bus.data_data_ok) ||
                    ((r_state == ST_WAIT) && bus.data_data_ok);

    // A flush after acceptance cannot cancel the bus transaction; it only
    // suppresses the write-back select.
    assign w_kill = flush_i && (w_accept || (r_state == ST_WAIT));

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_launch) begin
                    w_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.data_addr_ok) begin
                    w_next = bus.data_data_ok ? ST_DONE : ST_WAIT;
                end else if (flush_i) begin
                    w_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (bus.data_data_ok) begin
                    w_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bus request fields and write-back outputs
    // ------------------------------------------------------------------
    always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
        if (cpu_rst) begin
            r_is_load      <= 1'b0;
            bus.data_wr    <= 1'b0;
            bus.data_wstrb <= 4'b0000;
            bus.data_addr  <= '0;
            bus.data_wdata <= 32'h0000_0000;
            dre_o          <= DRE_NONE;
            device_o       <= 1'b0;
            dm_o           <= 32'h0000_0000;
        end else begin
            if (w_launch) begin
                r_is_load      <= w_is_load;
                bus.data_wr    <= w_is_store;
                bus.data_wstrb <= w_wstrb;
                bus.data_addr  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
                bus.data_wdata <= w_wdata;
                dre_o          <= w_dre;
                device_o       <= w_device;
            end
            if (w_kill) begin
                dre_o <= DRE_NONE;
            end
            if (w_resp && r_is_load) begin
                dm_o <= bus.data_rdata;
            end
        end
    end

    // Request is a pure decode of the state register, so it is glitch-free
    // and stays high until the address phase is accepted or flushed.
    assign bus.data_req = (r_state == ST_REQ);

    // Launch term stalls the very cycle the op arrives (no bubble).
    assign stall_req_o = (r_state == ST_REQ) || (r_state == ST_WAIT) || w_launch;

    assign adel_o = (r_state == ST_IDLE) && w_adel && !cpu_rst;
    assign ades_o = (r_state == ST_IDLE) && w_ades && !cpu_rst;

endmodule

`default_nettype wire
